// File: rtl/console_probe_pkg.sv
// Shared types and helpers for the console_probe power-on sequencer / famiclone detector.
package console_probe_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_PROBE    = 2'd1,
    ST_LOCK_STD = 2'd2,
    ST_LOCK_NEW = 2'd3
  } state_t;

  // All-ones value of a w-bit counter.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // A count parameter must be nonzero and representable in the counter width.
  function automatic bit param_ok(input int unsigned v, input int unsigned w);
    return (v >= 1) && (v <= cnt_max(w));
  endfunction

endpackage

// File: rtl/probe_down_counter.sv
// Loadable down counter that stops at zero; used for the init, lo and hi sample counts.
module probe_down_counter #(
  parameter int W = 4
) (
  input  logic         m2,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge m2) begin
    if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/console_probe.sv
// Power-on CIRAM grounding sequencer followed by a famiclone classifier that locks its result.
// Optional CONSOLE_PROBE_OVERRIDE_EN adds force_valid/force_new to override the classification.
module console_probe
  import console_probe_pkg::*;
#(
  parameter int CNT_W              = 4,
  parameter int INIT_CYCLES        = 15,
  parameter int SAMPLES_LO         = 2,
  parameter int SAMPLES_HI         = 2,
  parameter int MISMATCH_THRESHOLD = 1
) (
  input  logic             m2,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic             ppu_a13,
  input  logic             ppu_not_a13,
`ifdef CONSOLE_PROBE_OVERRIDE_EN
  input  logic             force_valid,
  input  logic             force_new,
`endif
  output logic             ground_en,
  output logic             probe_done,
  output logic             new_dendy,
  output logic [CNT_W-1:0] mismatch_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] INIT_V  = CNT_W'(INIT_CYCLES);
  localparam logic [CNT_W-1:0] LO_V    = CNT_W'(SAMPLES_LO);
  localparam logic [CNT_W-1:0] HI_V    = CNT_W'(SAMPLES_HI);
  localparam logic [CNT_W-1:0] THR_V   = CNT_W'(MISMATCH_THRESHOLD);

  if (!param_ok(INIT_CYCLES, CNT_W)) begin : g_bad_init
    $error("console_probe: INIT_CYCLES out of range for CNT_W");
  end
  if (!param_ok(SAMPLES_LO, CNT_W)) begin : g_bad_lo
    $error("console_probe: SAMPLES_LO out of range for CNT_W");
  end
  if (!param_ok(SAMPLES_HI, CNT_W)) begin : g_bad_hi
    $error("console_probe: SAMPLES_HI out of range for CNT_W");
  end
  if (!param_ok(MISMATCH_THRESHOLD, CNT_W)) begin : g_bad_thr
    $error("console_probe: MISMATCH_THRESHOLD out of range for CNT_W");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] init_cnt, lo_cnt, hi_cnt, mm_next;
  logic             init_zero, lo_zero, hi_zero;
  logic             frc_valid, frc_new;
  logic             probe_act, mismatch, mm_take, lo_en, hi_en, lo_done, hi_done;

`ifdef CONSOLE_PROBE_OVERRIDE_EN
  assign frc_valid = force_valid;
  assign frc_new   = force_new;
`else
  assign frc_valid = 1'b0;
  assign frc_new   = 1'b0;
`endif

  // A forced lock in PROBE pre-empts this edge's sample entirely.
  assign probe_act = (state == ST_PROBE) && sample_valid && !frc_valid;
  assign mismatch  = (ppu_a13 == ppu_not_a13);
  assign mm_take   = probe_act && mismatch && !lo_zero && !hi_zero;
  assign mm_next   = (mm_take && mismatch_count != CNT_MAX) ? mismatch_count + ONE : mismatch_count;
  assign lo_en     = probe_act && !ppu_a13;
  assign hi_en     = probe_act && ppu_a13;
  assign lo_done   = lo_zero || (lo_en && lo_cnt == ONE);
  assign hi_done   = hi_zero || (hi_en && hi_cnt == ONE);

  probe_down_counter #(.W(CNT_W)) u_init_cnt (
    .m2(m2), .load(reset), .load_val(INIT_V), .en(state == ST_INIT),
    .count(init_cnt), .zero(init_zero)
  );
  probe_down_counter #(.W(CNT_W)) u_lo_cnt (
    .m2(m2), .load(reset), .load_val(LO_V), .en(lo_en),
    .count(lo_cnt), .zero(lo_zero)
  );
  probe_down_counter #(.W(CNT_W)) u_hi_cnt (
    .m2(m2), .load(reset), .load_val(HI_V), .en(hi_en),
    .count(hi_cnt), .zero(hi_zero)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: begin
        if (init_cnt == ONE || init_zero) state_nxt = ST_PROBE;
      end
      ST_PROBE: begin
        if (frc_valid)
          state_nxt = frc_new ? ST_LOCK_NEW : ST_LOCK_STD;
        else if (mm_take && mm_next == THR_V)
          state_nxt = ST_LOCK_NEW;
        else if (probe_act && lo_done && hi_done)
          state_nxt = ST_LOCK_STD;
      end
      default: begin
        if (frc_valid) state_nxt = frc_new ? ST_LOCK_NEW : ST_LOCK_STD;
      end
    endcase
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      state          <= ST_INIT;
      mismatch_count <= '0;
    end else begin
      state          <= state_nxt;
      mismatch_count <= mm_next;
    end
  end

  assign ground_en  = (state == ST_INIT);
  assign probe_done = (state == ST_LOCK_STD) || (state == ST_LOCK_NEW);
  assign new_dendy  = (state == ST_LOCK_NEW);

endmodule

// File: doc/console_probe.md
Name: console_probe

Overview:
- Parametrised power-on sequencer and famiclone detector. It is the successor to the fixed 4-bit init and 2+2-sample "new Dendy" detector in the cartridge top level.
- Holds the CIRAM /CE and /A13 lines grounded for a configurable number of M2 cycles after reset.
- Then classifies the console from PPU A13 versus /A13 samples, using configurable sample depth and mismatch threshold, and locks the result.
- Sits beside the top-level output muxes; the top level uses ground_en, probe_done and new_dendy to drive ppu_ciram_ce and ppu_not_a13_out.

Parameters:
- CNT_W, 4, width of every internal counter.
- INIT_CYCLES, 15, M2 cycles the grounding phase lasts; legal range 1 to 2^CNT_W-1.
- SAMPLES_LO, 2, valid samples with A13=0 required before a standard-console lock; legal range 1 to 2^CNT_W-1.
- SAMPLES_HI, 2, valid samples with A13=1 required before a standard-console lock; legal range 1 to 2^CNT_W-1.
- MISMATCH_THRESHOLD, 1, mismatches that force a new-famiclone lock; legal range 1 to 2^CNT_W-1.

Ports:
- m2  in  1  the block's one clock (CPU M2); all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe: a PPU read has been captured since the previous edge.
- ppu_a13  in  1  captured PPU A13 of that read.
- ppu_not_a13  in  1  captured /A13 pin level of that read.
- ground_en  out  1  1 = top level drives CIRAM /CE and /A13 to 0.
- probe_done  out  1  classification locked.
- new_dendy  out  1  1 = new famiclone detected; valid only while probe_done=1.
- mismatch_count  out  CNT_W  saturating mismatch counter, for debug.

Behaviour:
- States: INIT, PROBE, LOCK_STD, LOCK_NEW; encoding is defined in the package.
- Reset values:
  - state INIT; init_cnt=INIT_CYCLES; lo_cnt=SAMPLES_LO; hi_cnt=SAMPLES_HI; mismatch_count=0.
  - Outputs: ground_en=1, probe_done=0, new_dendy=0.
- All outputs are registered or decoded directly from state; there is no combinational path from the inputs.
- INIT:
  - init_cnt decrements every edge.
  - The edge on which init_cnt goes from 1 to 0 moves to PROBE.
  - ground_en falls exactly INIT_CYCLES edges after the first edge with reset=0.
  - sample_valid is ignored.
- PROBE, on an edge with sample_valid=1:
  - Mismatch is defined as ppu_a13 == ppu_not_a13.
  - A mismatch is counted only if lo_cnt!=0 and hi_cnt!=0, evaluated before this edge's decrements.
  - mismatch_count increments and saturates at 2^CNT_W-1.
  - If ppu_a13=0 and lo_cnt!=0, lo_cnt decrements; if ppu_a13=1 and hi_cnt!=0, hi_cnt decrements.
- PROBE transitions:
  - The post-increment mismatch_count reaching MISMATCH_THRESHOLD moves to LOCK_NEW.
  - Otherwise, lo_cnt and hi_cnt both 0 after decrement moves to LOCK_STD.
  - If both conditions hold on the same edge, LOCK_NEW wins.
- PROBE with no sample_valid: holds indefinitely; there is no timeout.
- LOCK_STD / LOCK_NEW:
  - probe_done=1; new_dendy=1 only in LOCK_NEW.
  - Counters freeze and inputs are ignored.
  - State is held until reset.
- Reset asserted in any state, including mid-INIT or mid-PROBE: return to reset values on that edge. ground_en reasserts the same cycle it is registered.
- No counter wraps below 0.

Optional Feature:
- Macro: CONSOLE_PROBE_OVERRIDE_EN.
- Enabled:
  - Adds ports force_valid (in, 1) and force_new (in, 1).
  - force_valid=1 in PROBE, or in either LOCK state, moves to LOCK_NEW if force_new=1, else LOCK_STD, on that edge.
  - force_valid in PROBE takes priority over sample handling on the same edge.
  - Ignored in INIT.
- Disabled: ports are absent; behaviour is exactly as above.

Decomposition:
- Package console_probe_pkg holds:
  - the state typedef and encodings;
  - a localparam helper for the CNT_W maximum value;
  - a parameter legality check function, used by elaboration-time assertions.
- One sub-module: probe_down_counter (loadable, enable, stop-at-zero, zero flag). It is instantiated for init_cnt, lo_cnt and hi_cnt.
- The mismatch counter stays inline.

Test Plan:
- Default parameters, reset released at cycle 0 → ground_en=1 through edge 14; ground_en=0 and state PROBE after edge 15; samples during INIT leave mismatch_count=0.
- PROBE, samples (a13,/a13) = (0,1),(1,0),(0,1),(1,0) → probe_done=1, new_dendy=0 after the 4th sample; mismatch_count=0.
- PROBE, first sample (1,1) → LOCK_NEW on that edge; new_dendy=1, mismatch_count=1; later samples change nothing.
- MISMATCH_THRESHOLD=2, SAMPLES_LO=SAMPLES_HI=1:
  - samples (0,0),(1,0) → second sample zeroes hi_cnt with mismatch_count=1 → LOCK_STD.
  - repeat with (0,0),(1,1) → second sample sees lo_cnt=0, so no count is taken → LOCK_STD.
- INIT_CYCLES=3, reset reasserted at edge 2, then during PROBE → every output returns to reset values on the next edge; ground_en restarts its full 3-cycle count.
- CONSOLE_PROBE_OVERRIDE_EN defined, force_valid=1, force_new=1 in LOCK_STD → LOCK_NEW next edge; force_valid during INIT → no effect.
